// File: rtl/tap_autorange_ctrl.sv
// Auto-ranging sequencer for the front-end tap/gain step: settle, evaluate a window, step down/up.
// Optional build macro FAST_OVER_EN: over-range in SETTLE/EVAL jumps straight to STEP_MIN.
module tap_autorange_ctrl #(
  parameter logic [3:0]  STEP_MAX   = 4'd10,
  parameter logic [3:0]  STEP_MIN   = 4'd5,
  parameter logic [15:0] SETTLE_CYC = 16'd1000,
  parameter logic [15:0] WIN_CYC    = 16'd256
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] inputCmd,
  input  logic        inputCmdTrigger,
  input  logic        overDec,
  input  logic        underDec,
  output logic [3:0]  tapStep,
  output logic        rangeValid,
  output logic        overRange,
  output logic        rangeChange
);
  typedef enum logic [1:0] {SETTLE, EVAL, MANUAL} state_t;

  localparam logic [3:0] OP_RESTART = 4'd6;
  localparam logic [3:0] OP_MANUAL  = 4'd7;
  localparam logic [3:0] OP_AUTO    = 4'd8;

  // Bit 0 carries overDec, bit 1 carries underDec.
  logic [1:0] asyncIn;
  logic [1:0] syncOut;
  assign asyncIn = {underDec, overDec};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gSync
      logic meta_reg;
      logic stable_reg;
      always_ff @(posedge clk) begin
        if (rest) begin
          meta_reg   <= 1'b0;
          stable_reg <= 1'b0;
        end else begin
          meta_reg   <= asyncIn[gi];
          stable_reg <= meta_reg;
        end
      end
      assign syncOut[gi] = stable_reg;
    end
  endgenerate

  logic ovS, unS;
  assign ovS = syncOut[0];
  assign unS = syncOut[1];

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [3:0]  tapStep_reg, tapStep_next;
  logic        rangeValid_reg, rangeValid_next;
  logic        overRange_reg, overRange_next;
  logic        rangeChange_reg;
  logic        ovSeen_reg, ovSeen_next;
  logic        unAll_reg, unAll_next;
  logic        trigD_reg;

  logic       cmdPos;
  logic [3:0] opcode, arg, argClamped;
  logic       settleEnd, winEnd, ovAcc, unAcc;
  logic       unusedCmdBits;

  assign cmdPos        = inputCmdTrigger & ~trigD_reg;
  assign opcode        = inputCmd[31:28];
  assign arg           = inputCmd[3:0];
  assign unusedCmdBits = ^inputCmd[27:4];
  assign argClamped    = (arg < STEP_MIN) ? STEP_MIN : ((arg > STEP_MAX) ? STEP_MAX : arg);
  assign settleEnd     = (cnt_reg == SETTLE_CYC - 16'd1);
  assign winEnd        = (cnt_reg == WIN_CYC - 16'd1);
  // Include the current cycle so the window really spans WIN_CYC samples.
  assign ovAcc         = ovSeen_reg | ovS;
  assign unAcc         = unAll_reg & unS;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + 16'd1;
    tapStep_next    = tapStep_reg;
    rangeValid_next = rangeValid_reg;
    overRange_next  = overRange_reg;
    ovSeen_next     = ovSeen_reg;
    unAll_next      = unAll_reg;
    if (cmdPos && opcode == OP_RESTART) begin
      tapStep_next    = STEP_MAX;
      overRange_next  = 1'b0;
      rangeValid_next = 1'b0;
      state_next      = SETTLE;
      cnt_next        = 16'd0;
    end else if (cmdPos && opcode == OP_MANUAL) begin
      tapStep_next    = argClamped;
      rangeValid_next = 1'b1;
      state_next      = MANUAL;
      cnt_next        = 16'd0;
    end else if (cmdPos && opcode == OP_AUTO) begin
      rangeValid_next = 1'b0;
      state_next      = SETTLE;
      cnt_next        = 16'd0;
`ifdef FAST_OVER_EN
    end else if (ovS && state_reg != MANUAL) begin
      tapStep_next    = STEP_MIN;
      rangeValid_next = 1'b0;
      state_next      = SETTLE;
      cnt_next        = 16'd0;
      if (tapStep_reg == STEP_MIN) overRange_next = 1'b1;
`endif
    end else begin
      case (state_reg)
        SETTLE: begin
          if (settleEnd) begin
            state_next  = EVAL;
            cnt_next    = 16'd0;
            ovSeen_next = 1'b0;
            unAll_next  = 1'b1;
          end
        end
        EVAL: begin
          ovSeen_next = ovAcc;
          unAll_next  = unAcc;
          if (winEnd) begin
            cnt_next    = 16'd0;
            ovSeen_next = 1'b0;
            unAll_next  = 1'b1;
            if (ovAcc && tapStep_reg > STEP_MIN) begin
              tapStep_next    = tapStep_reg - 4'd1;
              rangeValid_next = 1'b0;
              state_next      = SETTLE;
            end else if (ovAcc) begin
              overRange_next  = 1'b1;
              rangeValid_next = 1'b1;
            end else if (unAcc && tapStep_reg < STEP_MAX) begin
              tapStep_next    = tapStep_reg + 4'd1;
              rangeValid_next = 1'b0;
              state_next      = SETTLE;
            end else begin
              rangeValid_next = 1'b1;
            end
          end
        end
        MANUAL: begin
          cnt_next = cnt_reg;
          if (ovS && tapStep_reg == STEP_MIN) overRange_next = 1'b1;
        end
        default: begin
          state_next = SETTLE;
          cnt_next   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_reg       <= SETTLE;
      cnt_reg         <= 16'd0;
      tapStep_reg     <= STEP_MAX;
      rangeValid_reg  <= 1'b0;
      overRange_reg   <= 1'b0;
      rangeChange_reg <= 1'b0;
      ovSeen_reg      <= 1'b0;
      unAll_reg       <= 1'b0;
      trigD_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      tapStep_reg     <= tapStep_next;
      rangeValid_reg  <= rangeValid_next;
      overRange_reg   <= overRange_next;
      rangeChange_reg <= (tapStep_next != tapStep_reg);
      ovSeen_reg      <= ovSeen_next;
      unAll_reg       <= unAll_next;
      trigD_reg       <= inputCmdTrigger;
    end
  end

  assign tapStep     = tapStep_reg;
  assign rangeValid  = rangeValid_reg;
  assign overRange   = overRange_reg;
  assign rangeChange = rangeChange_reg;
endmodule
